// File: rtl/regfile_debug_port.sv
// rtl/regfile_debug_port.sv - debug initiator that dumps/loads the 32-entry register file over streams
module regfile_debug_port #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump_start,
  input  logic                  load_start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            rf_read_register,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic [4:0]            rf_write_register,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [4:0]            out_index,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data
);

  localparam int NUM_REGISTERS = 32;
  localparam int IDX_WIDTH     = $clog2(NUM_REGISTERS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGISTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DUMP_FETCH = 2'd1,
    S_DUMP_SEND  = 2'd2,
    S_LOAD       = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [IDX_WIDTH-1:0]    r_idx;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [IDX_WIDTH-1:0]    r_out_index;
  logic                    r_done;
  logic                    w_out_hs;
  logic                    w_in_hs;
  logic                    w_last;

  assign w_out_hs  = out_valid && out_ready;
  assign w_in_hs   = in_valid && in_ready;
  assign w_last    = (r_idx == LAST_IDX);
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // handshakes are already gated by abort, so an aborted op never pulses done
      r_done  <= (w_out_hs || w_in_hs) && w_last;
      case (r_state)
        S_IDLE: begin
          if (dump_start)      r_idx <= '0;
          else if (load_start) r_idx <= IDX_WIDTH'(1);
        end
        S_DUMP_FETCH: begin
          r_out_data  <= rf_read_data;
          r_out_index <= r_idx;
        end
        S_DUMP_SEND: if (w_out_hs && !w_last) r_idx <= r_idx + 1'b1;
        S_LOAD:      if (w_in_hs && !w_last)  r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (dump_start)      w_next_state = S_DUMP_FETCH;
        else if (load_start) w_next_state = S_LOAD;
      end
      S_DUMP_FETCH: w_next_state = abort ? S_IDLE : S_DUMP_SEND;
      S_DUMP_SEND: begin
        if (abort)         w_next_state = S_IDLE;
        else if (w_out_hs) w_next_state = w_last ? S_IDLE : S_DUMP_FETCH;
      end
      S_LOAD: begin
        if (abort)                  w_next_state = S_IDLE;
        else if (w_in_hs && w_last) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // rst gates the handshake outputs so a reset cycle can never write the register file
  always_comb begin
    busy              = (r_state != S_IDLE);
    out_valid         = (r_state == S_DUMP_SEND) && !abort && !rst;
    in_ready          = (r_state == S_LOAD) && !abort && !rst;
    rf_read_register  = (r_state == S_DUMP_FETCH) ? r_idx : '0;
    rf_write_register = '0;
    rf_write_data     = '0;
    if (in_valid && in_ready) begin
      rf_write_register = r_idx;
      rf_write_data     = in_data;
    end
  end

endmodule

// File: tb/tb_regfile_debug_port.sv
// tb/tb_regfile_debug_port.sv - randomized bench for regfile_debug_port against a transaction-level model
module tb_regfile_debug_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        dump_start, load_start, abort;
  logic        busy, done;
  logic [4:0]  rf_read_register, rf_write_register, out_index;
  logic [31:0] rf_read_data, rf_write_data, out_data, in_data;
  logic        out_valid, out_ready, in_valid, in_ready;

  regfile_debug_port #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .dump_start(dump_start), .load_start(load_start), .abort(abort),
    .busy(busy), .done(done), .rf_read_register(rf_read_register), .rf_read_data(rf_read_data),
    .rf_write_register(rf_write_register), .rf_write_data(rf_write_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  always #5 clk = ~clk;

  // register file environment
  logic [31:0] rf_mem [32];
  logic [31:0] pre_val [32];
  logic        pre_en;
  assign rf_read_data = rf_mem[rf_read_register];
  always @(posedge clk) begin
    if (pre_en) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= pre_val[i];
    end else if (rf_write_register != 5'd0) begin
      rf_mem[rf_write_register] <= rf_write_data;
    end
  end

  // model and scoreboard state
  int          n_cmp = 0, n_fail = 0;
  logic [31:0] model_rf [32];
  logic [31:0] cap_data [32];
  int          hs_cyc [32];
  logic [31:0] q[$];
  logic        m_busy = 1'b0, exp_done = 1'b0;
  int          exp_dump_idx = 0, exp_load_idx = 1;
  int          beats = 0, writes = 0, done_cnt = 0, cyc_n = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic [4:0]  prev_index = '0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic monitor();
    logic hs_out, hs_in, fin;
    cyc_n++;
    chk("busy", busy, m_busy);
    chk("done", done, exp_done);
    if (done) done_cnt++;
    if (!m_busy) begin
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_write", rf_write_register, 0);
    end
    if (abort && m_busy) begin
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_write", rf_write_register, 0);
    end
    if (prev_hold && !abort && !rst) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
      chk("hold_index", out_index, prev_index);
    end
    hs_out = out_valid && out_ready;
    hs_in  = in_valid && in_ready;
    if (hs_out) begin
      if (exp_dump_idx < 32) begin
        chk("dump_index", out_index, exp_dump_idx);
        chk("dump_data", out_data, model_rf[exp_dump_idx]);
        cap_data[exp_dump_idx] = out_data;
        hs_cyc[exp_dump_idx] = cyc_n;
      end else begin
        chk("dump_extra_beat", exp_dump_idx, 31);
      end
      beats++;
      exp_dump_idx++;
    end
    if (hs_in || rf_write_register != 5'd0) chk("write_iff_in_hs", rf_write_register != 5'd0, hs_in);
    if (rf_write_register != 5'd0) begin
      chk("write_index", rf_write_register, exp_load_idx);
      chk("write_data", rf_write_data, in_data);
      model_rf[rf_write_register] = rf_write_data;
      writes++;
      exp_load_idx++;
      if (q.size() > 0) void'(q.pop_front());
    end
    fin = (hs_out && out_index == 5'd31) || (rf_write_register == 5'd31);
    exp_done = !rst && fin;
    if (rst) m_busy = 1'b0;
    else if (!m_busy) m_busy = dump_start || load_start;
    else m_busy = !(fin || abort);
    prev_hold  = out_valid && !out_ready;
    prev_data  = out_data;
    prev_index = out_index;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
      in_valid = 1'b1;
      in_data  = q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = 32'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    #2;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_rd_reg"}, rf_read_register, 0);
    chk({tag, "_wr_reg"}, rf_write_register, 0);
    chk({tag, "_wr_data"}, rf_write_data, 0);
  endtask

  task automatic preload(input logic [31:0] base);
    for (int i = 0; i < 32; i++) begin
      pre_val[i]  = (i == 0) ? 32'd0 : base + 32'(i);
      model_rf[i] = pre_val[i];
    end
    pre_en = 1'b1;
    cyc();
    pre_en = 1'b0;
  endtask

  task automatic run_dump(input int mode, input logic both);
    int n, w0, d0;
    exp_dump_idx = 0; beats = 0; w0 = writes; d0 = done_cnt; n = 0;
    rdy_mode = mode;
    dump_start = 1'b1; load_start = both;
    cyc();
    dump_start = 1'b0; load_start = 1'b0;
    while (done_cnt == d0 && n < 2000) begin cyc(); n++; end
    chk("dump_timeout", n < 2000, 1);
    chk("dump_beats", beats, 32);
    chk("dump_no_writes", writes - w0, 0);
    chk("dump_done_once", done_cnt - d0, 1);
    if (mode == 0)
      for (int i = 1; i < 32; i++) chk("dump_gap", hs_cyc[i] - hs_cyc[i-1], 2);
  endtask

  task automatic run_load(input logic [31:0] base, input int abort_after);
    int n, w0, d0;
    exp_load_idx = 1; w0 = writes; d0 = done_cnt; n = 0;
    for (int k = 0; k < 31; k++) q.push_back(base + 32'(k));
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    if (abort_after == 0) begin
      while (done_cnt == d0 && n < 2000) begin cyc(); n++; end
      chk("load_timeout", n < 2000, 1);
      chk("load_writes", writes - w0, 31);
      chk("load_done_once", done_cnt - d0, 1);
    end else begin
      while (writes - w0 < abort_after && n < 2000) begin cyc(); n++; end
      chk("abort_wait_timeout", n < 2000, 1);
      abort = 1'b1; in_valid = 1'b1; in_data = q[0];
      cyc();
      abort = 1'b0;
      q.delete();
      in_valid = 1'b0;
      cyc();
      cyc();
      chk("abort_writes", writes - w0, abort_after);
      chk("abort_no_done", done_cnt - d0, 0);
    end
    q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; dump_start = 1'b0; load_start = 1'b0; abort = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0; pre_en = 1'b0;
    repeat (3) cyc();
    check_all_zero("reset");
    rst = 1'b0;
    cyc();

    preload(32'h100);
    run_dump(0, 1'b0);
    chk("pin_dump_x0", cap_data[0], 32'h0);
    chk("pin_dump_x1", cap_data[1], 32'h101);
    chk("pin_dump_x31", cap_data[31], 32'h11F);

    run_dump(1, 1'b0);

    run_load(32'hA000, 0);
    chk("pin_load_x1", rf_mem[1], 32'hA000);
    chk("pin_load_x31", rf_mem[31], 32'hA01E);
    run_dump(1, 1'b0);
    chk("pin_redump_x0", cap_data[0], 32'h0);
    chk("pin_redump_x31", cap_data[31], 32'hA01E);

    run_dump(0, 1'b1);

    run_load(32'hB000, 10);
    chk("pin_abort_x10", rf_mem[10], 32'hB009);
    chk("pin_abort_x11", rf_mem[11], 32'hA00A);
    run_load(32'hC000, 0);
    chk("pin_reload_x1", rf_mem[1], 32'hC000);
    chk("pin_reload_x31", rf_mem[31], 32'hC01E);

    rdy_mode = 0; exp_dump_idx = 0; beats = 0; n = 0;
    dump_start = 1'b1;
    cyc();
    dump_start = 1'b0;
    while (beats < 5 && n < 2000) begin cyc(); n++; end
    rdy_mode = 2; out_ready = 1'b0;
    while (!(out_valid && out_index == 5'd5) && n < 2000) begin cyc(); n++; end
    chk("rst_wait_timeout", n < 2000, 1);
    n = done_cnt;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_all_zero("midrst");
    cyc();
    chk("midrst_no_done", done_cnt - n, 0);
    run_dump(1, 1'b0);
    chk("pin_after_rst_x0", cap_data[0], 32'h0);
    chk("pin_after_rst_x5", cap_data[5], 32'hC004);

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
